// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock.
// Define LEAD_BLANK_EN to replace leading zero digits with BLANK_CODE.
module bin_to_bcd_seq #(
   parameter int         WIDTH      = 14,
   parameter logic [3:0] BLANK_CODE = 4'hF
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic [WIDTH-1:0] BIN,
   output logic [3:0]       units,
   output logic [3:0]       tens,
   output logic [3:0]       hundreds,
   output logic [3:0]       thousands,
   output logic             BUSY,
   output logic             DONE,
   output logic             OVF
);
   localparam int SW = 16 + WIDTH;
   localparam int CW = $clog2(WIDTH);
`ifdef LEAD_BLANK_EN
   localparam bit LB = 1'b1;
`else
   localparam bit LB = 1'b0;
`endif
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t        r_state;
   logic [SW-1:0] r_sr;
   logic [CW-1:0] r_cnt;
   logic          r_ovf_pend;
   logic [SW-1:0] w_adj, w_next;
   logic [3:0]    w_d [4];
   logic [3:0]    w_o [4];
   logic          w_b3, w_b2, w_b1;
   assign w_adj[WIDTH-1:0] = r_sr[WIDTH-1:0];
   for (genvar i = 0; i < 4; i++) begin : g_dig
      assign w_adj[WIDTH+4*i +: 4] = (r_sr[WIDTH+4*i +: 4] >= 4'd5) ? r_sr[WIDTH+4*i +: 4] + 4'd3
                                                                      : r_sr[WIDTH+4*i +: 4];
      assign w_d[i] = w_next[WIDTH+4*i +: 4];
   end
   assign w_next = {w_adj[SW-2:0], 1'b0};
   // Blank only a leading run of zeros; saturated results are all nines so never blank.
   assign w_b3 = LB && !r_ovf_pend && (w_d[3] == 4'd0);
   assign w_b2 = w_b3 && (w_d[2] == 4'd0);
   assign w_b1 = w_b2 && (w_d[1] == 4'd0);
   always_comb begin
      w_o[0] = r_ovf_pend ? 4'd9 : w_d[0];
      w_o[1] = r_ovf_pend ? 4'd9 : (w_b1 ? BLANK_CODE : w_d[1]);
      w_o[2] = r_ovf_pend ? 4'd9 : (w_b2 ? BLANK_CODE : w_d[2]);
      w_o[3] = r_ovf_pend ? 4'd9 : (w_b3 ? BLANK_CODE : w_d[3]);
   end
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state    <= IDLE;
         r_sr       <= '0;
         r_cnt      <= '0;
         r_ovf_pend <= 1'b0;
         units      <= 4'd0;
         tens       <= 4'd0;
         hundreds   <= 4'd0;
         thousands  <= 4'd0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
         OVF        <= 1'b0;
      end else begin
         DONE <= 1'b0;
         if (r_state == IDLE) begin
            if (START) begin
               r_sr       <= {16'd0, BIN};
               r_ovf_pend <= {{(32-WIDTH){1'b0}}, BIN} > 32'd9999;
               r_cnt      <= '0;
               BUSY       <= 1'b1;
               r_state    <= SHIFT;
            end
         end else begin
            r_sr  <= w_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(WIDTH-1)) begin
               units     <= w_o[0];
               tens      <= w_o[1];
               hundreds  <= w_o[2];
               thousands <= w_o[3];
               OVF       <= r_ovf_pend;
               DONE      <= 1'b1;
               BUSY      <= 1'b0;
               r_state   <= IDLE;
            end
         end
      end
   end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed self-checking bench for bin_to_bcd_seq (WIDTH=14).
// Expectations follow LEAD_BLANK_EN when it is defined.
module tb_bin_to_bcd_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [13:0] bin = '0;
   logic [3:0]  units, tens, hundreds, thousands;
   logic        busy, done, ovf;
   logic [15:0] w_dig;
   logic [15:0] prev_dig = 16'h0000;
   logic        prev_ovf = 1'b0;
   int          n_chk = 0;
   int          n_fail = 0;
   bin_to_bcd_seq dut (
      .CLK(clk), .RST_N(rst_n), .START(start), .BIN(bin),
      .units(units), .tens(tens), .hundreds(hundreds), .thousands(thousands),
      .BUSY(busy), .DONE(done), .OVF(ovf)
   );
   assign w_dig = {thousands, hundreds, tens, units};
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [15:0] bl(input logic [15:0] r);
      logic [15:0] v;
      v = r;
`ifdef LEAD_BLANK_EN
      if (v[15:12] == 4'h0) begin
         v[15:12] = 4'hF;
         if (v[11:8] == 4'h0) begin
            v[11:8] = 4'hF;
            if (v[7:4] == 4'h0) v[7:4] = 4'hF;
         end
      end
`endif
      return v;
   endfunction
   task automatic kick(input logic [13:0] b);
      start = 1'b1;
      bin   = b;
      @(negedge clk);
      start = 1'b0;
      bin   = 14'h2AAA;
   endtask
   task automatic wait_done(input string tag, input int lat);
      int k;
      bit bad_hold, bad_busy;
      k = 0;
      bad_hold = 0;
      bad_busy = 0;
      while (!done && k < 40) begin
         if (w_dig !== prev_dig || ovf !== prev_ovf) bad_hold = 1;
         if (busy !== 1'b1) bad_busy = 1;
         @(negedge clk);
         k++;
      end
      check({tag, "_lat"}, k, lat);
      check({tag, "_hold"}, bad_hold, 0);
      check({tag, "_busy"}, bad_busy, 0);
      check({tag, "_busy_end"}, busy, 0);
   endtask
   task automatic res(input string tag, input logic [15:0] exp, input logic exp_ovf);
      check({tag, "_dig"}, w_dig, exp);
      check({tag, "_ovf"}, ovf, exp_ovf);
      prev_dig = exp;
      prev_ovf = exp_ovf;
   endtask
   task automatic run(input string tag, input logic [13:0] b, input logic [15:0] exp, input logic exp_ovf);
      kick(b);
      wait_done(tag, 14);
      res(tag, exp, exp_ovf);
      @(negedge clk);
      check({tag, "_pulse"}, done, 0);
   endtask
   initial begin
      bit saw_done;
      repeat (2) @(negedge clk);
      check("rst_dig", w_dig, 16'h0000);
      check("rst_flags", {busy, done, ovf}, 3'b000);
      rst_n = 1'b1;
      @(negedge clk);
      run("b1234", 14'd1234, 16'h1234, 1'b0);
      run("b0", 14'd0, bl(16'h0000), 1'b0);
      run("b9999", 14'd9999, 16'h9999, 1'b0);
      run("b10000", 14'd10000, 16'h9999, 1'b1);
      run("b7", 14'd7, bl(16'h0007), 1'b0);
      run("b16383", 14'd16383, 16'h9999, 1'b1);
      // A START mid-conversion must be dropped, and START in the DONE cycle accepted.
      kick(14'd321);
      repeat (4) @(negedge clk);
      start = 1'b1;
      bin   = 14'd555;
      @(negedge clk);
      start = 1'b0;
      wait_done("b321", 9);
      res("b321", bl(16'h0321), 1'b0);
      kick(14'd4096);
      check("b2b_busy", busy, 1);
      check("b2b_done", done, 0);
      wait_done("b4096", 14);
      res("b4096", 16'h4096, 1'b0);
      @(negedge clk);
      kick(14'd5000);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mid_rst_dig", w_dig, 16'h0000);
      check("mid_rst_flags", {busy, done, ovf}, 3'b000);
      saw_done = 0;
      for (int i = 0; i < 20; i++) begin
         if (done || busy) saw_done = 1;
         @(negedge clk);
      end
      check("mid_rst_quiet", saw_done, 0);
      prev_dig = 16'h0000;
      prev_ovf = 1'b0;
      run("b88", 14'd88, bl(16'h0088), 1'b0);
      run("b1005", 14'd1005, 16'h1005, 1'b0);
      run("b12000", 14'd12000, 16'h9999, 1'b1);
`ifdef LEAD_BLANK_EN
      run("blk42", 14'd42, 16'hFF42, 1'b0);
      run("blk0", 14'd0, 16'hFFF0, 1'b0);
      run("blk1005", 14'd1005, 16'h1005, 1'b0);
`else
      run("raw42", 14'd42, 16'h0042, 1'b0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using the double-dabble (shift-and-add-3) method, one bit per clock.
- Produces the four BCD digit codes (units/tens/hundreds/thousands) that feed the multiplexed 7-segment display path.
- Accepts a binary count from counters or debounced-input logic through a START/BUSY/DONE handshake.
- Holds the last result stable between conversions, so the display never shows intermediate values.

Parameters:
- WIDTH, 14, binary input width. Legal range 4..14. At 14, inputs up to 16383 are accepted and values above 9999 saturate.
- BLANK_CODE, 4'hF, digit code emitted for a blanked leading zero (used only with LEAD_BLANK_EN).

Ports:
- CLK  input  1  system clock, rising-edge.
- RST_N  input  1  reset, synchronous, active-low.
- START  input  1  conversion request, sampled only in IDLE.
- BIN  input  WIDTH  unsigned binary value, sampled on the accepting edge.
- units  output  4  BCD digit 0 (registered).
- tens  output  4  BCD digit 1 (registered).
- hundreds  output  4  BCD digit 2 (registered).
- thousands  output  4  BCD digit 3 (registered).
- BUSY  output  1  high while a conversion is in progress.
- DONE  output  1  one-cycle pulse when results update.
- OVF  output  1  last completed conversion had BIN > 9999.

Behaviour:
- Reset (RST_N=0 at an edge):
  - All digit outputs, BUSY, DONE and OVF go to 0. State goes to IDLE. Shift register and bit counter are cleared.
  - Reset mid-conversion aborts the conversion. No DONE is produced and outputs read 0.
- States: IDLE and SHIFT.
- IDLE:
  - At an edge with START=1, capture BIN into the low part of a (16+WIDTH)-bit shift register with the BCD part zeroed.
  - Latch ovf_pend = (BIN > 9999). Clear the bit counter. Enter SHIFT with BUSY=1.
- SHIFT:
  - Each edge: every BCD nibble >= 5 gets +3 (4-bit add, no carry out), then the whole register shifts left by 1. The counter increments.
  - On the WIDTH-th SHIFT edge, the register output of that step is written to the digit outputs.
  - If ovf_pend is set, all four digits are forced to 9 instead.
  - OVF is set to ovf_pend, DONE is set to 1 for exactly one cycle, BUSY goes to 0, and state returns to IDLE.
- Latency: DONE is high during the cycle following the WIDTH-th edge after the capture edge (14 cycles for the default).
- START handling:
  - Ignored while BUSY=1, with no queuing. BIN changes during BUSY have no effect.
  - Back-to-back: START=1 in the DONE cycle is accepted (state is already IDLE), and BUSY is high the next cycle.
- Digit outputs and OVF change only on the DONE edge and hold otherwise.
- WIDTH < 14: OVF is never set.

Optional Feature:
- Macro: LEAD_BLANK_EN.
- Defined:
  - On the DONE edge, leading zero digits are replaced by BLANK_CODE, scanning from thousands downward and stopping at the first nonzero digit.
  - units is never blanked.
  - Interior zeros are never blanked.
  - Saturated results are not blanked.
- Undefined: digits are always raw BCD 0..9. BLANK_CODE is unused.

Test Plan:
- BIN=1234, 1-cycle START → BUSY for 14 cycles, then DONE pulse. thousands=1, hundreds=2, tens=3, units=4, OVF=0.
- BIN=9999 → 9,9,9,9 with OVF=0. BIN=10000 → 9,9,9,9 with OVF=1. A following BIN=7 → 0,0,0,7 with OVF=0.
- BIN=0 → 0,0,0,0 and DONE. Outputs hold previous value throughout BUSY (check against prior result 1234).
- Accepting START for BIN=321, then START with BIN=555 at cycle 5 → ignored, result 0,3,2,1. Then START in the DONE cycle with BIN=4096 → BUSY next cycle, result 4,0,9,6.
- RST_N=0 for one edge at SHIFT cycle 7 → all outputs 0, BUSY=0, no DONE. A new START with BIN=88 → 0,0,8,8.
- With LEAD_BLANK_EN:
  - BIN=42 → F,F,4,2.
  - BIN=0 → F,F,F,0.
  - BIN=1005 → 1,0,0,5.
  - BIN=12000 → 9,9,9,9 with OVF=1.
